// File: rtl/mac_acc.sv
// mac_acc: sign-magnitude multiply-accumulate of VEC_LEN A*B beats onto an addend C.
// Define MAC_ACC_SAT_EN to saturate MOUT on overflow and report it on OVF; otherwise MOUT wraps.
module mac_acc #(
    parameter int A_BITWIDTH   = 8,
    parameter int B_BITWIDTH   = A_BITWIDTH,
    parameter int C_BITWIDTH   = 8,
    parameter int FRAC_A       = 6,
    parameter int FRAC_B       = 6,
    parameter int FRAC_C       = 6,
    parameter int OUT_BITWIDTH = 16,
    parameter int VEC_LEN      = 4
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    START,
    input  logic [C_BITWIDTH-1:0]   DATA_C,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [A_BITWIDTH-1:0]   DATA_A,
    input  logic [B_BITWIDTH-1:0]   DATA_B,
    output logic [OUT_BITWIDTH-1:0] MOUT,
    output logic                    DONE,
    output logic                    BUSY,
    output logic                    OVF
);

    localparam int ProdW  = A_BITWIDTH + B_BITWIDTH - 2;
    localparam int CShift = FRAC_A + FRAC_B - FRAC_C;
    localparam int CAlnW  = C_BITWIDTH - 1 + CShift;
    localparam int AccW   = ((ProdW > CAlnW) ? ProdW : CAlnW) + $clog2(VEC_LEN) + 2;
    localparam int CntW   = $clog2(VEC_LEN + 1);
    localparam int MagW   = OUT_BITWIDTH - 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StOut} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic               w_start;
    logic               w_accept;
    logic               w_last;
    logic               w_load_out;

    logic [CntW-1:0]    r_cnt;
    logic [ProdW-1:0]   r_prod_mag;
    logic               r_prod_sign;
    logic               r_prod_vld;
    logic [AccW-1:0]    r_acc;
    logic [OUT_BITWIDTH-1:0] r_mout;
    logic               r_done;

    logic [ProdW-1:0]   w_prod_mag;
    logic               w_prod_sign;
    logic [AccW-1:0]    w_prod_ext;
    logic [AccW-1:0]    w_prod_val;
    logic [AccW-1:0]    w_c_mag;
    logic [AccW-1:0]    w_c_val;
    logic               w_acc_neg;
    logic [AccW-1:0]    w_acc_abs;
    logic [MagW-1:0]    w_mag_out;

    // ---------------------------------------------------------------- control FSM
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_last = (r_cnt == CntW'(VEC_LEN - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_load_out  = 1'b0;
        IN_READY    = 1'b0;
        BUSY        = (r_state != StIdle);
        unique case (r_state)
            StIdle: begin
                if (START) begin
                    w_start     = 1'b1;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_state_nxt = StDrain;
                    end
                end
            end
            StDrain: begin
                w_state_nxt = StOut;
            end
            StOut: begin
                w_load_out  = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    // ---------------------------------------------------------------- product stage
    assign w_prod_mag  = ProdW'(DATA_A[A_BITWIDTH-2:0]) * ProdW'(DATA_B[B_BITWIDTH-2:0]);
    assign w_prod_sign = DATA_A[A_BITWIDTH-1] ^ DATA_B[B_BITWIDTH-1];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_prod_vld  <= 1'b0;
            r_prod_mag  <= '0;
            r_prod_sign <= 1'b0;
        end else begin
            r_prod_vld <= w_accept;
            if (w_accept) begin
                r_prod_mag  <= w_prod_mag;
                r_prod_sign <= w_prod_sign;
            end
        end
    end

    // ---------------------------------------------------------------- accumulate stage
    // Negative zero needs no special case: negating a zero magnitude yields zero.
    assign w_prod_ext = AccW'(r_prod_mag);
    assign w_prod_val = r_prod_sign ? (-w_prod_ext) : w_prod_ext;
    assign w_c_mag    = AccW'(DATA_C[C_BITWIDTH-2:0]) << CShift;
    assign w_c_val    = DATA_C[C_BITWIDTH-1] ? (-w_c_mag) : w_c_mag;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_acc <= '0;
        end else if (w_start) begin
            r_acc <= w_c_val;
        end else if (r_prod_vld) begin
            r_acc <= r_acc + w_prod_val;
        end
    end

    // ---------------------------------------------------------------- result conversion
    assign w_acc_neg = r_acc[AccW-1];
    assign w_acc_abs = w_acc_neg ? (-r_acc) : r_acc;

`ifdef MAC_ACC_SAT_EN
    localparam int CmpW = (AccW > OUT_BITWIDTH) ? AccW : OUT_BITWIDTH;

    logic [CmpW-1:0] w_abs_ext;
    logic [CmpW-1:0] w_mag_max;
    logic            w_ovf;
    logic            r_ovf;

    assign w_abs_ext = CmpW'(w_acc_abs);
    assign w_mag_max = {{(CmpW - MagW){1'b0}}, {MagW{1'b1}}};
    assign w_ovf     = (w_abs_ext > w_mag_max);
    assign w_mag_out = w_ovf ? {MagW{1'b1}} : MagW'(w_acc_abs);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_ovf <= 1'b0;
        end else if (w_load_out) begin
            r_ovf <= w_ovf;
        end
    end

    assign OVF = r_ovf;
`else
    assign w_mag_out = MagW'(w_acc_abs);
    assign OVF       = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_mout <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_load_out;
            if (w_load_out) begin
                r_mout <= {w_acc_neg, w_mag_out};
            end
        end
    end

    assign MOUT = r_mout;
    assign DONE = r_done;

endmodule

// File: tb/tb_mac_acc.sv
// Scoreboard bench for mac_acc at default parameters; stimulus pushes expectations,
// a negedge monitor pops them whenever DONE is seen.
module tb_mac_acc;

    logic        CLK      = 1'b0;
    logic        RSTn     = 1'b1;
    logic        START    = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [7:0]  DATA_C   = '0;
    logic [7:0]  DATA_A   = '0;
    logic [7:0]  DATA_B   = '0;
    logic        IN_READY;
    logic        DONE;
    logic        BUSY;
    logic        OVF;
    logic [15:0] MOUT;

    mac_acc dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .START    (START),
        .DATA_C   (DATA_C),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .DATA_A   (DATA_A),
        .DATA_B   (DATA_B),
        .MOUT     (MOUT),
        .DONE     (DONE),
        .BUSY     (BUSY),
        .OVF      (OVF)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] mout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] last_mout = '0;

`ifdef MAC_ACC_SAT_EN
    localparam logic [15:0] Exp3M = 16'h7FFF;
    localparam logic        Exp3O = 1'b1;
`else
    localparam logic [15:0] Exp3M = 16'h1BC4;
    localparam logic        Exp3O = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (DONE) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got DONE=1, expected DONE=0 (cyc %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("mout", {16'h0, MOUT}, {16'h0, mon_e.mout});
                chk("ovf", {31'h0, OVF}, {31'h0, mon_e.ovf});
                chk("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the OUT state.
    task automatic do_op(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                         input bit gappy, input bit mid_start,
                         input logic [15:0] exp_m, input logic exp_o);
        int   beats = 0;
        int   iter  = 0;
        exp_t e;
        START  = 1'b1;
        DATA_C = c;
        @(negedge CLK);
        START  = 1'b0;
        DATA_C = 8'h7F;
        chk("busy_run", {31'h0, BUSY}, 32'd1);
        chk("ready_run", {31'h0, IN_READY}, 32'd1);
        while (beats < 4 && iter < 30) begin
            IN_VALID = gappy ? ((iter % 2) == 0) : 1'b1;
            DATA_A   = IN_VALID ? a : 8'h7F;
            DATA_B   = IN_VALID ? b : 8'h7F;
            START    = mid_start && (iter == 1);
            if (IN_VALID && IN_READY) begin
                beats++;
                if (beats == 4) begin
                    e.mout = exp_m;
                    e.ovf  = exp_o;
                    e.cyc  = cyc + 3;
                    sb.push_back(e);
                end
            end
            iter++;
            @(negedge CLK);
        end
        START = 1'b0;
        chk("beat_count", beats, 32'd4);
        // DRAIN: junk offered on IN_VALID must be ignored.
        chk("ready_drain", {31'h0, IN_READY}, 32'd0);
        IN_VALID = 1'b1;
        DATA_A   = 8'h7F;
        DATA_B   = 8'h7F;
        @(negedge CLK);
        IN_VALID  = 1'b0;
        last_mout = exp_m;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((BUSY || sb.size() != 0) && t < 20) begin
            @(negedge CLK);
            t++;
        end
        @(negedge CLK);
        chk("idle_reached", {31'h0, (BUSY || sb.size() != 0)}, 32'd0);
        chk("done_low", {31'h0, DONE}, 32'd0);
        chk("mout_hold", {16'h0, MOUT}, {16'h0, last_mout});
    endtask

    task automatic chk_reset_outputs();
        chk("rst_mout", {16'h0, MOUT}, 32'd0);
        chk("rst_done", {31'h0, DONE}, 32'd0);
        chk("rst_ovf", {31'h0, OVF}, 32'd0);
        chk("rst_busy", {31'h0, BUSY}, 32'd0);
        chk("rst_ready", {31'h0, IN_READY}, 32'd0);
    endtask

    initial begin
        int t;
        int dones;
        #1 RSTn = 1'b0;
        #1 chk_reset_outputs();
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);

        do_op(8'h40, 8'h40, 8'h40, 1'b0, 1'b0, 16'h5000, 1'b0);
        wait_idle();
        do_op(8'h00, 8'hC0, 8'h40, 1'b0, 1'b0, 16'hC000, 1'b0);
        wait_idle();
        do_op(8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b0, Exp3M, Exp3O);
        wait_idle();
        do_op(8'h80, 8'h80, 8'h05, 1'b0, 1'b0, 16'h0000, 1'b0);
        wait_idle();
        do_op(8'h40, 8'h40, 8'h40, 1'b1, 1'b1, 16'h5000, 1'b0);
        wait_idle();

        // Reset after two accepted beats: operation abandoned, no DONE.
        START  = 1'b1;
        DATA_C = 8'h40;
        @(negedge CLK);
        START    = 1'b0;
        IN_VALID = 1'b1;
        DATA_A   = 8'h40;
        DATA_B   = 8'h40;
        @(negedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        #2 RSTn = 1'b0;
        #1 chk_reset_outputs();
        @(negedge CLK);
        RSTn  = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        chk("no_done_after_reset", dones, 32'd0);
        last_mout = 16'h0000;
        chk("mout_after_reset", {16'h0, MOUT}, 32'd0);

        do_op(8'h20, 8'hE0, 8'h20, 1'b0, 1'b0, 16'hA800, 1'b0);
        wait_idle();

        // Back-to-back: second START issued in the DONE cycle of the first.
        do_op(8'h00, 8'h05, 8'h03, 1'b0, 1'b0, 16'h003C, 1'b0);
        t = 0;
        while (!DONE && t < 10) begin
            @(negedge CLK);
            t++;
        end
        chk("done_seen", {31'h0, DONE}, 32'd1);
        do_op(8'hC1, 8'h03, 8'h81, 1'b0, 1'b0, 16'h904C, 1'b0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_acc.md
MAC_ACC -- requirements
Module: mac_acc

Interface
REQ-001 SHALL provide parameter A_BITWIDTH, default 8, width of DATA_A in sign-magnitude (MSB sign).
REQ-002 SHALL provide parameter B_BITWIDTH, default A_BITWIDTH, width of DATA_B in sign-magnitude.
REQ-003 SHALL provide parameter C_BITWIDTH, default 8, width of DATA_C in sign-magnitude.
REQ-004 SHALL provide parameter FRAC_A, default 6, fraction bits of DATA_A; FRAC_B, default 6, of DATA_B; FRAC_C, default 6, of DATA_C; FRAC_C <= FRAC_A+FRAC_B.
REQ-005 SHALL provide parameter OUT_BITWIDTH, default 16, sign-magnitude MOUT width, fraction FRAC_A+FRAC_B.
REQ-006 SHALL provide parameter VEC_LEN, default 4, range 1..256, number of A*B beats per operation.
REQ-007 One clock, CLK; reset asynchronous active-low, RSTn.
REQ-008 Ports: CLK in 1 clock; RSTn in 1 async active-low reset; START in 1 begin operation; DATA_C in C_BITWIDTH addend; IN_VALID in 1 beat valid; IN_READY out 1 beat ready; DATA_A in A_BITWIDTH; DATA_B in B_BITWIDTH; MOUT out OUT_BITWIDTH result; DONE out 1 result pulse; BUSY out 1 operation active; OVF out 1 result overflowed.

Function
REQ-009 Result SHALL equal DATA_C + sum over VEC_LEN accepted beats of DATA_A*DATA_B, all values sign-magnitude, computed exactly in an internal two's-complement accumulator of width max(A_BITWIDTH+B_BITWIDTH-2, C_BITWIDTH-1+FRAC_A+FRAC_B-FRAC_C)+clog2(VEC_LEN)+2.
REQ-010 States: IDLE, RUN, DRAIN, OUT; BUSY SHALL be 1 in every state except IDLE.
REQ-011 IDLE: START=1 at an edge SHALL latch DATA_C, left-shifted by FRAC_A+FRAC_B-FRAC_C, into accumulator, clear beat counter, go RUN; START outside IDLE SHALL be ignored.
REQ-012 RUN: IN_READY SHALL be 1; a beat is accepted at an edge with IN_VALID=1 and IN_READY=1; gaps (IN_VALID=0) SHALL stall without effect.
REQ-013 Accepted beat: sign=A_sign XOR B_sign, magnitude product registered at the accept edge, added to accumulator at the following edge (2-stage pipeline, back-to-back beats allowed).
REQ-014 On the edge accepting beat VEC_LEN, state SHALL go DRAIN; IN_READY SHALL be 0 in DRAIN, OUT, IDLE; IN_VALID there SHALL be ignored.
REQ-015 DRAIN: one cycle, last product absorbed, go OUT; OUT: one cycle, MOUT/DONE/OVF registered, go IDLE.
REQ-016 Latency: DONE SHALL be 1 in exactly the cycle following the edge 2 cycles after the last accept edge; with START at edge s and no gaps, DONE visible after edge s+VEC_LEN+2.
REQ-017 DONE SHALL be a one-cycle pulse; MOUT and OVF SHALL hold until the next DONE.
REQ-018 START asserted in the DONE cycle SHALL be accepted (state is IDLE), enabling back-to-back operations.
REQ-019 Negative-zero inputs (sign 1, magnitude 0) SHALL be treated as zero; a zero result SHALL be output with sign 0.
REQ-020 Result conversion: sign = accumulator sign, magnitude = |accumulator|; overflow when magnitude > 2^(OUT_BITWIDTH-1)-1 (see Configuration).

Reset
REQ-021 RSTn=0 SHALL immediately force state IDLE, MOUT=0, DONE=0, OVF=0, BUSY=0, IN_READY=0, clear accumulator, counter, pipeline.
REQ-022 Reset mid-operation SHALL abandon the operation with no DONE pulse; the first edge after release SHALL behave as IDLE.

Configuration
REQ-023 Macro MAC_ACC_SAT_EN defined: overflow SHALL clamp magnitude to 2^(OUT_BITWIDTH-1)-1, keep sign, and set OVF=1 with DONE.
REQ-024 MAC_ACC_SAT_EN undefined: overflow SHALL keep low OUT_BITWIDTH-1 magnitude bits (wrap); OVF SHALL be constant 0; saturation logic absent.

Verification (defaults)
REQ-025 START with C=0x40; 4 beats A=0x40,B=0x40 back-to-back -> MOUT=0x5000, OVF=0, DONE 6 edges after START edge.
REQ-026 C=0x00; 4 beats A=0xC0,B=0x40 -> MOUT=0xC000 (-4.0).
REQ-027 C=0x7F; 4 beats A=0x7F,B=0x7F -> with MAC_ACC_SAT_EN MOUT=0x7FFF, OVF=1; without MOUT=0x1BC4, OVF=0.
REQ-028 C=0x80; 4 beats A=0x80,B=0x05 -> MOUT=0x0000, sign 0.
REQ-029 Beats with IN_VALID toggling 1,0,1,0,...; START pulsed mid-RUN -> extra START ignored, DONE exactly 2 cycles after 4th accept, result as REQ-025.
REQ-030 RSTn low after 2 beats -> no DONE; new START after release yields correct independent result; START in DONE cycle -> second operation accepted.
